conv_encoder_k4: RTL



---
 rtl/conv_encoder_k4.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/conv_encoder_k4.sv
// Rate-1/2, K=4 (8-state) convolutional encoder with 3-bit zero tail per frame.
// Valid/ready on both sides; a one-entry registered output stage absorbs backpressure.
module conv_encoder_k4 #(
  parameter logic [3:0] G0    = 4'b1101,
  parameter logic [3:0] G1    = 4'b1111,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_sym,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] sym_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  function automatic logic parity4(input logic [3:0] v);
    return ^v;
  endfunction

  // Symbol {c0,c1} for input b given shift state s (s[2] is the newest bit).
  function automatic logic [1:0] encode(input logic b, input logic [2:0] s);
    logic [3:0] vec;
    vec = {b, s};
    return {parity4(G0 & vec), parity4(G1 & vec)};
  endfunction

  state_t           state_r,     state_nxt_s;
  logic [2:0]       shift_r,     shift_nxt_s;
  logic [1:0]       tail_cnt_r,  tail_cnt_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic [1:0]       out_sym_r,   out_sym_nxt_s;
  logic             out_last_r,  out_last_nxt_s;
  logic [CNT_W-1:0] sym_count_r, sym_count_nxt_s;
  logic             busy_r,      busy_nxt_s;

  logic       slot_free_s;
  logic       in_ready_s;
  logic       accept_s;
  logic       tail_step_s;
  logic       tail_done_s;
  logic       load_s;
  logic       bit_s;
  logic [1:0] sym_s;

  // Handshake qualifiers and the symbol that would be loaded this cycle.
  always_comb begin
    slot_free_s = !out_valid_r || out_ready;
    in_ready_s  = slot_free_s && ((state_r == ST_IDLE) || (state_r == ST_DATA));
    accept_s    = in_valid && in_ready_s;
    tail_step_s = (state_r == ST_TAIL) && slot_free_s;
    tail_done_s = tail_step_s && (tail_cnt_r == 2'd2);
    load_s      = accept_s || tail_step_s;
    if (accept_s) begin
      bit_s = in_bit;
    end else begin
      bit_s = 1'b0;
    end
    sym_s = encode(bit_s, shift_r);
  end

  // Next-state computation for FSM, shift register, output stage and counter.
  always_comb begin
    state_nxt_s     = state_r;
    tail_cnt_nxt_s  = tail_cnt_r;
    shift_nxt_s     = shift_r;
    out_valid_nxt_s = out_valid_r;
    out_sym_nxt_s   = out_sym_r;
    out_last_nxt_s  = out_last_r;
    sym_count_nxt_s = sym_count_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s    = in_last ? ST_TAIL : ST_DATA;
          tail_cnt_nxt_s = 2'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (accept_s && in_last) begin
          state_nxt_s    = ST_TAIL;
          tail_cnt_nxt_s = 2'd0;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_TAIL: begin
        if (tail_done_s) begin
          state_nxt_s    = ST_IDLE;
          tail_cnt_nxt_s = 2'd0;
        end else if (tail_step_s) begin
          tail_cnt_nxt_s = tail_cnt_r + 2'd1;
        end else begin
          state_nxt_s = ST_TAIL;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        tail_cnt_nxt_s = 2'd0;
      end
    endcase

    // The shift register is never forced: three zero tail bits flush it to 000.
    if (load_s) begin
      out_valid_nxt_s = 1'b1;
      out_sym_nxt_s   = sym_s;
      out_last_nxt_s  = tail_done_s;
      shift_nxt_s     = {bit_s, shift_r[2:1]};
    end else if (out_ready) begin
      out_valid_nxt_s = 1'b0;
      out_last_nxt_s  = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end

    if (accept_s && (state_r == ST_IDLE)) begin
      sym_count_nxt_s = CNT_W'(1);
    end else if (load_s && !(&sym_count_r)) begin
      sym_count_nxt_s = sym_count_r + CNT_W'(1);
    end else begin
      sym_count_nxt_s = sym_count_r;
    end

    busy_nxt_s = (state_nxt_s != ST_IDLE) || out_valid_nxt_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      tail_cnt_r  <= 2'd0;
      shift_r     <= 3'b000;
      out_valid_r <= 1'b0;
      out_sym_r   <= 2'b00;
      out_last_r  <= 1'b0;
      sym_count_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      tail_cnt_r  <= tail_cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_sym_r   <= out_sym_nxt_s;
      out_last_r  <= out_last_nxt_s;
      sym_count_r <= sym_count_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_sym   = out_sym_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign sym_count = sym_count_r;

endmodule
